// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: FSM state encoding and default sizing.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]  wr_ptr_reg;
    logic [ADDR_W:0]  rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem_reg[rd_ptr_reg[ADDR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: rx synchroniser, baud tick detect, framing FSM and receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic                 baud_in,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic                 baud_q_reg, baud_qq_reg;
    logic [2:0]           state_reg, state_next;
    logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] data_sr_reg, data_sr_next;
    logic                 armed_reg, armed_next;
    logic                 frame_err_reg;
    logic                 overrun_reg;
    logic                 tick, rx_fall, rx;
    logic                 push_req, frame_err_set, overrun_set;
    logic                 fifo_full, fifo_empty, par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bad_reg, par_bad_next;
    logic parity_err_reg, parity_err_set;
    assign par_ok = ~par_bad_reg;
`else
    assign par_ok = 1'b1;
`endif

    assign tick    = baud_q_reg & ~baud_qq_reg;
    assign rx      = rx_sync_reg;
    assign rx_fall = rx_prev_reg & ~rx_sync_reg;

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        data_sr_next  = data_sr_reg;
        armed_next    = armed_reg | rx;
        push_req      = 1'b0;
        frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next   = par_bad_reg;
        parity_err_set = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (rx_en && armed_reg && rx_fall) begin
                    state_next    = ST_START;
                    tick_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_next  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_MID) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        state_next    = rx ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        data_sr_next  = {rx, data_sr_reg[DATA_BITS-1:1]};
                        bit_cnt_next  = bit_cnt_reg + BIT_W'(1);
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt_reg == BIT_LAST) state_next = ST_PARITY;
`else
                        if (bit_cnt_reg == BIT_LAST) state_next = ST_STOP;
`endif
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        state_next    = ST_STOP;
                        if (rx != ^data_sr_reg) begin
                            parity_err_set = 1'b1;
                            par_bad_next   = 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        state_next    = ST_IDLE;
                        if (rx) begin
                            push_req = par_ok;
                        end else begin
                            // Line still low: wait for it to go high before hunting for a new start.
                            frame_err_set = 1'b1;
                            armed_next    = 1'b0;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (!rx_en) begin
            state_next    = ST_IDLE;
            push_req      = 1'b0;
            frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_set = 1'b0;
`endif
        end
    end

    assign overrun_set = push_req && fifo_full && !rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            rx_prev_reg   <= 1'b1;
            baud_q_reg    <= 1'b0;
            baud_qq_reg   <= 1'b0;
            state_reg     <= ST_IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            data_sr_reg   <= '0;
            armed_reg     <= 1'b1;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            rx_meta_reg   <= rx_i;
            rx_sync_reg   <= rx_meta_reg;
            rx_prev_reg   <= rx_sync_reg;
            baud_q_reg    <= baud_in;
            baud_qq_reg   <= baud_q_reg;
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            data_sr_reg   <= data_sr_next;
            armed_reg     <= armed_next;
            frame_err_reg <= frame_err_set;
            if (overrun_set)  overrun_reg <= 1'b1;
            else if (clr_err) overrun_reg <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            par_bad_reg    <= par_bad_next;
            parity_err_reg <= parity_err_set;
        end
    end
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (data_sr_reg),
        .pop       (rx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rx_data)
    );

    assign rx_valid  = ~fifo_empty;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive sequencer for the SimpleRISC SoC. It consumes the divided oversample signal from the RX baud-rate generator and synchronises the serial input. It detects start bits, samples each bit at mid-point, and assembles bytes into a small FIFO that the CPU drains through a valid/ready handshake. It sits between the RX baud generator and the memory-mapped UART register block.

## Interface
Parameters:
- OVERSAMPLE, 16, baud-generator ticks per bit; must be even, ≥ 8
- DATA_BITS, 8, payload bits per frame, LSB first
- FIFO_DEPTH, 4, receive FIFO entries; power of two

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- rx_i  input  1  raw serial line; idle high; asynchronous to clk
- baud_in  input  1  RX baud generator output; each rising edge is one oversample tick
- rx_en  input  1  receiver enable
- rx_data  output  DATA_BITS  head-of-FIFO byte
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer pops head when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration)
- overrun  output  1  sticky: byte received while FIFO full
- clr_err  input  1  clears overrun
- busy  output  1  FSM not in IDLE

## Operation
- rx_i passes through a 2-FF synchroniser; both flops reset to 1.
- baud_in is registered and edge-detected. tick = baud_q & ~baud_qq, one clk wide.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - On a synchronised falling edge of rx while rx_en is high, go to START and clear tick_cnt.
- START:
  - Count OVERSAMPLE/2 ticks to the mid-point of the start bit.
  - If rx = 1 there, it is a false start: return to IDLE with no error.
  - Otherwise go to DATA with bit_cnt = 0.
- DATA:
  - Every OVERSAMPLE ticks, sample rx into the shift register, LSB first.
  - After DATA_BITS samples, go to PARITY (macro) or STOP.
- STOP:
  - Sample after OVERSAMPLE ticks.
  - rx = 1: push the byte and return to IDLE.
  - rx = 0: pulse frame_err, discard the byte, and return to IDLE. IDLE re-arms only after rx is seen high.
- FIFO push and pop in the same cycle at full: the pop frees the slot, the push is accepted, overrun stays clear.
- Push while full without a pop: byte dropped, overrun set. overrun is cleared by clr_err; a set in the same cycle as clr_err wins.
- rx_en deasserted mid-frame: return to IDLE on the next clk, partial byte discarded, FIFO and overrun untouched.
- Counters: tick_cnt is $clog2(OVERSAMPLE) bits and wraps to 0 at each sample; bit_cnt is $clog2(DATA_BITS+1) bits.

## Timing
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
  - FSM in IDLE, FIFO empty.
- rx_i to start detection: 3 clk (2 synchroniser flops + edge register).
- baud_in rising edge to tick: 2 clk.
- rx_valid rises 1 clk after the stop-sample tick when the FIFO was empty.
- rx_data is valid whenever rx_valid is high and is stable until popped.
- Pop takes effect at the clock edge where rx_valid && rx_ready; the next entry appears the following cycle.
- frame_err and parity_err assert in the cycle after the sampling tick.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state sampled after OVERSAMPLE ticks; even parity over the data bits.
  - Mismatch pulses parity_err and discards the byte; the frame still proceeds to STOP.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; frames are 8N1.
  - parity_err is tied to 0 and the port remains.

## Structure
- Package uart_rx_pkg holds:
  - FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit)
  - Default OVERSAMPLE, DATA_BITS and FIFO_DEPTH constants.
- Sub-module uart_rx_fifo:
  - Synchronous FIFO with push, pop, full, empty and head data.
  - Read/write pointers one bit wider than the address, for full/empty discrimination.
- Top level holds the synchroniser, tick edge detector, FSM, counters and error logic.

## Test plan
- Frame 0xA5, 8N1, rx_ready = 1: rx_valid pulses once with rx_data = 0xA5; no errors.
- Low glitch of 4 ticks on idle rx: no frame started, busy returns to 0, rx_valid stays 0.
- Frame 0x3C with stop bit 0: frame_err pulses one cycle; FIFO stays empty; receiver recovers and accepts the next 0x55.
- Five frames 0x01–0x05 with rx_ready = 0:
  - FIFO holds 0x01–0x04 and overrun = 1.
  - Draining yields 0x01, 0x02, 0x03, 0x04.
  - clr_err clears overrun.
- rx_en dropped after 3 data bits: busy falls next clk; no push; a following frame 0x7E is received intact.
- With UART_RX_PARITY_EN: 0x0F with parity bit 1 gives parity_err and no push; 0x0F with parity bit 0 is accepted.
